// File: rtl/counter_down_100.sv
// Loadable 7-bit countdown timer (0..CNT_MAX) with programmable tick prescaler.
// Supports pause, abort, restart, zero-load and out-of-range start rejection.
module counter_down_100 #(
    parameter int CNT_MAX  = 99,
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [6:0] i_init,
    input  logic       i_pause,
    input  logic       i_stop,
    output logic [6:0] o_cnt,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    LOAD_MAX   = 7'(CNT_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    // Single registered FSM: every output comes from a flop, so no input reaches
    // an output combinationally.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            presc  <= '0;
            o_cnt  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;

            if (i_stop) begin
                // Abort keeps the count visible; any start in the same cycle is dropped.
                if (state == RUN) begin
                    state  <= IDLE;
                    presc  <= '0;
                    o_busy <= 1'b0;
                end
            end else if (i_start) begin
                if (i_init > LOAD_MAX) begin
                    o_err <= 1'b1;
                end else if (i_init == 7'd0) begin
                    state  <= IDLE;
                    presc  <= '0;
                    o_cnt  <= '0;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end else begin
                    state  <= RUN;
                    presc  <= '0;
                    o_cnt  <= i_init;
                    o_busy <= 1'b1;
                end
            end else if (state == RUN && !i_pause) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    // The 1 -> 0 step ends the run; the guard keeps o_cnt from wrapping.
                    if (o_cnt <= 7'd1) begin
                        o_cnt  <= '0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        o_cnt <= o_cnt - 7'd1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule
